alu_sliced: RTL and testbench

- Parametrised multi-cycle ALU built from a chain of add/logic bit-slices, processed SLICE bits per cycle, least-significant slice first, with a registered carry between slices.
- Replaces single-bit slice instantiation in the execute stage.
- Trades latency for area: an operation takes WIDTH/SLICE cycles.
- Valid/ready handshakes on both sides let the pipeline stall around it.
- Produces a result plus carry, overflow, zero and negative flags.

---
 rtl/alu_sliced.sv | 167 ++++++++++++++++
 tb/tb_alu_sliced.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sliced.sv
// alu_sliced: multi-cycle ALU that processes SLICE bits per cycle,
// least-significant slice first, with a registered carry between slices.
// An operation takes WIDTH/SLICE cycles from acceptance to out_valid.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   request handshake; A, B, op sampled on acceptance
//   op                    000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                         101 SLT (signed), 110/111 reserved (result 0)
//   out_valid / out_ready result handshake; result and flags held in DONE
//   result                WIDTH-bit result
//   carry_out, overflow   arithmetic flags (ADD/SUB/SLT only, else 0)
//   zero, negative        derived from the final result
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// RUN   | one slice per cycle, cnt counts remaining slices down to 0
// DONE  | result and flags valid, waiting for out_ready
module alu_sliced #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = SLICE + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT            stateQ, stateNext;
  logic [WIDTH-1:0] aSh, bSh, accQ, accNext, finalRes;
  logic [2:0]       opQ;
  logic             carryQ;
  logic [CW-1:0]    cnt;

  logic             subOp, arithOp, lastSlice, ovf;
  logic [SLICE-1:0] aS, bS, bsS, sliceRes;
  logic [SW-1:0]    sumWide;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) stateQ <= IDLE;
    else       stateQ <= stateNext;
  end

  // FSM next state and handshake outputs
  always_comb begin
    stateNext = stateQ;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (stateQ)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) stateNext = RUN;
      end
      RUN: begin
        if (lastSlice) stateNext = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Slice datapath: operands are shifted right each cycle so the current
  // slice always sits in the low bits; on the last slice the low bits hold
  // the operand MSBs, which is what the overflow term needs.
  always_comb begin
    subOp     = (opQ == OP_SUB) || (opQ == OP_SLT);
    arithOp   = (opQ == OP_ADD) || subOp;
    lastSlice = (cnt == '0);
    aS        = aSh[SLICE-1:0];
    bS        = bSh[SLICE-1:0];
    bsS       = bS ^ {SLICE{subOp}};
    sumWide   = {1'b0, aS} + {1'b0, bsS} + SW'(carryQ);
    ovf       = (aS[SLICE-1] == bsS[SLICE-1]) && (sumWide[SLICE-1] != aS[SLICE-1]);

    case (opQ)
      OP_ADD, OP_SUB, OP_SLT: sliceRes = sumWide[SLICE-1:0];
      OP_AND:                 sliceRes = aS & bS;
      OP_OR:                  sliceRes = aS | bS;
      OP_XOR:                 sliceRes = aS ^ bS;
      default:                sliceRes = '0;
    endcase

    // New slice enters at the top; after N cycles slice 0 reaches bit 0.
    accNext = (accQ >> SLICE) | (WIDTH'(sliceRes) << (WIDTH - SLICE));

    case (opQ)
      OP_SLT:                         finalRes = WIDTH'(sumWide[SLICE-1] ^ ovf);
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR:                         finalRes = accNext;
      default:                        finalRes = '0;
    endcase
  end

  // Datapath registers; result and flags only change on the final slice edge
  always_ff @(posedge clk) begin
    if (reset) begin
      aSh       <= '0;
      bSh       <= '0;
      opQ       <= '0;
      carryQ    <= 1'b0;
      cnt       <= '0;
      accQ      <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (in_valid) begin
            aSh    <= A;
            bSh    <= B;
            opQ    <= op;
            carryQ <= (op == OP_SUB) || (op == OP_SLT);
            cnt    <= CNT_LOAD;
          end
        end
        RUN: begin
          aSh    <= aSh >> SLICE;
          bSh    <= bSh >> SLICE;
          accQ   <= accNext;
          carryQ <= arithOp & sumWide[SLICE];
          if (lastSlice) begin
            result    <= finalRes;
            carry_out <= arithOp & sumWide[SLICE];
            overflow  <= arithOp & ovf;
            zero      <= (finalRes == '0);
            negative  <= finalRes[WIDTH-1];
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sliced.sv
// Bench for alu_sliced: three instances (SLICE = 8, 32, 1) share one
// directed suite. A spec-level model (plain 33-bit arithmetic and signed
// compare) predicts every result; a monitor compares on each valid cycle.
module tb_alu_sliced;

  logic        clk = 1'b0;
  logic        rst[3];
  logic        inValid[3];
  logic        inReady[3];
  logic        outValid[3];
  logic        outReady[3];
  logic [31:0] aIn[3];
  logic [31:0] bIn[3];
  logic [2:0]  opIn[3];
  logic [31:0] res[3];
  logic        cOut[3];
  logic        ovf[3];
  logic        zf[3];
  logic        nf[3];

  logic [31:0] expRes[3];
  logic [3:0]  expFl[3];
  bit          armed[3];
  bit          prevOv[3];
  int          doneCyc[3];

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gDut
    alu_sliced #(.WIDTH(32), .SLICE(g == 0 ? 8 : (g == 1 ? 32 : 1))) dut (
      .clk       (clk),
      .reset     (rst[g]),
      .in_valid  (inValid[g]),
      .in_ready  (inReady[g]),
      .A         (aIn[g]),
      .B         (bIn[g]),
      .op        (opIn[g]),
      .out_valid (outValid[g]),
      .out_ready (outReady[g]),
      .result    (res[g]),
      .carry_out (cOut[g]),
      .overflow  (ovf[g]),
      .zero      (zf[g]),
      .negative  (nf[g])
    );
  end

  function automatic int nOf(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 32);
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut=%0d cyc=%0d actual=%h expected=%h", name, k, cyc, act, exp);
    end
  endtask

  // Spec-level model: flags packed as {carry, overflow, zero, negative}
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [3:0] f);
    logic [32:0] s;
    logic c, v;
    s = '0; c = 1'b0; v = 1'b0; r = '0;
    case (o)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      3'd1, 3'd5: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        c = s[32];
        v = (a[31] != b[31]) && (s[31] != a[31]);
        if (o == 3'd1) r = s[31:0];
        else           r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: r = '0;
    endcase
    f = {c, v, (r == 32'd0), r[31]};
  endtask

  // Compare process: every cycle out_valid is high the outputs must match
  // the model, the rising edge must land exactly N edges after acceptance,
  // and in_ready must be low.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (outValid[k]) begin
        if (!armed[k]) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid dut=%0d cyc=%0d actual=1 expected=0", k, cyc);
        end else begin
          if (!prevOv[k]) chk("latency", k, cyc, doneCyc[k]);
          chk("result", k, res[k], expRes[k]);
          chk("flags", k, {28'd0, cOut[k], ovf[k], zf[k], nf[k]}, {28'd0, expFl[k]});
          chk("in_ready_busy", k, {31'd0, inReady[k]}, 32'd0);
        end
      end
      prevOv[k] = outValid[k];
    end
  end

  task automatic accept(input int k, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [3:0]  f;
    @(negedge clk);
    aIn[k] = a; bIn[k] = b; opIn[k] = o; inValid[k] = 1'b1;
    chk("in_ready_idle", k, {31'd0, inReady[k]}, 32'd1);
    @(posedge clk); #1;
    inValid[k] = 1'b0;
    model(o, a, b, r, f);
    expRes[k]  = r;
    expFl[k]   = f;
    doneCyc[k] = cyc + nOf(k);
    armed[k]   = 1'b1;
  endtask

  task automatic doOp(input int k, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input int hold, input logic [31:0] litRes, input logic [3:0] litFl);
    bit got;
    int t;
    accept(k, o, a, b);
    got = 1'b0;
    t = 0;
    while (!got && t < nOf(k) + 4) begin
      @(negedge clk);
      if (outValid[k]) got = 1'b1;
      t++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout dut=%0d op=%0d actual=no_valid expected=valid", k, o);
      armed[k] = 1'b0;
      return;
    end
    chk("lit_result", k, res[k], litRes);
    chk("lit_flags", k, {28'd0, cOut[k], ovf[k], zf[k], nf[k]}, {28'd0, litFl});
    repeat (hold) begin
      aIn[k] = $urandom; bIn[k] = $urandom; opIn[k] = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    outReady[k] = 1'b1;
    @(posedge clk); #1;
    armed[k] = 1'b0;
    outReady[k] = 1'b0;
    @(negedge clk);
    chk("valid_after_consume", k, {31'd0, outValid[k]}, 32'd0);
    chk("ready_after_consume", k, {31'd0, inReady[k]}, 32'd1);
  endtask

  task automatic checkResetState(input int k, input string tag);
    chk({tag, "_in_ready"}, k, {31'd0, inReady[k]}, 32'd1);
    chk({tag, "_out_valid"}, k, {31'd0, outValid[k]}, 32'd0);
    chk({tag, "_result"}, k, res[k], 32'd0);
    chk({tag, "_flags"}, k, {28'd0, cOut[k], ovf[k], zf[k], nf[k]}, 32'd0);
  endtask

  // Reset arrives two edges into the operation (mid-RUN, or DONE when N=1),
  // with in_valid also high on the reset edge; reset must win.
  task automatic midReset(input int k);
    accept(k, 3'd0, 32'h1234_5678, 32'h1111_1111);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst[k] = 1'b1;
    inValid[k] = 1'b1; aIn[k] = 32'hDEAD_BEEF; bIn[k] = 32'h1; opIn[k] = 3'd1;
    @(posedge clk); #1;
    armed[k] = 1'b0;
    @(negedge clk);
    checkResetState(k, "mid_reset");
    rst[k] = 1'b0;
    inValid[k] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; inValid[k] = 1'b0; outReady[k] = 1'b0;
      aIn[k] = '0; bIn[k] = '0; opIn[k] = '0;
      armed[k] = 1'b0; prevOv[k] = 1'b0; expRes[k] = '0; expFl[k] = '0; doneCyc[k] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) checkResetState(k, "reset");
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    for (int k = 0; k < 3; k++) begin
      doOp(k, 3'd0, 32'h0000_00FF, 32'h0000_0001, 0, 32'h0000_0100, 4'b0000);
      doOp(k, 3'd1, 32'h8000_0000, 32'h0000_0001, 0, 32'h7FFF_FFFF, 4'b1100);
      doOp(k, 3'd1, 32'h0000_0005, 32'h0000_0005, 0, 32'h0000_0000, 4'b1010);
      doOp(k, 3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0001, 4'b1000);
      doOp(k, 3'd5, 32'h7FFF_FFFF, 32'h8000_0000, 0, 32'h0000_0000, 4'b0110);
      doOp(k, 3'd2, 32'hF0F0_A5A5, 32'hFF00_5A5A, 0, 32'hF000_0000, 4'b0001);
      doOp(k, 3'd3, 32'hF0F0_A5A5, 32'hFF00_5A5A, 0, 32'hFFF0_FFFF, 4'b0001);
      doOp(k, 3'd4, 32'hF0F0_A5A5, 32'hFF00_5A5A, 0, 32'h0FF0_FFFF, 4'b0000);
      doOp(k, 3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0000, 4'b0010);
      doOp(k, 3'd7, 32'h8000_0001, 32'h8000_0001, 0, 32'h0000_0000, 4'b0010);
      doOp(k, 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 4'b1010);
      doOp(k, 3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5, 32'h8000_0000, 4'b0101);
      midReset(k);
      doOp(k, 3'd0, 32'h0000_0001, 32'h0000_0002, 0, 32'h0000_0003, 4'b0000);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
